// File: rtl/eco32_core_idu_rfu_pkg.sv
// rtl/eco32_core_idu_rfu_pkg.sv - shared types and helpers for the IDU register file
// Optional feature macro: ECO32_CORE_IDU_RFU_ZERO_REG_EN (hardwired zero register).
package eco32_core_idu_rfu_pkg;

  typedef enum logic {RFU_CLEAR, RFU_READY} rfu_state_t;

  localparam int RFU_LANE_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/eco32_core_idu_rfu_lane.sv
// rtl/eco32_core_idu_rfu_lane.sv - one 8-bit byte lane, one write port, RD_PORTS async read taps
// Optional feature macro: ECO32_CORE_IDU_RFU_ZERO_REG_EN (handled in the top, not here).
module eco32_core_idu_rfu_lane
  import eco32_core_idu_rfu_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int RD_PORTS = 2,
  parameter int AW       = 5
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [AW-1:0]                  waddr,
  input  logic [RFU_LANE_W-1:0]          wdata,
  input  logic [RD_PORTS*AW-1:0]         raddr,
  output logic [RD_PORTS*RFU_LANE_W-1:0] rdata
);

  logic [RFU_LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_tap
    assign rdata[p*RFU_LANE_W +: RFU_LANE_W] = mem[raddr[p*AW +: AW]];
  end

endmodule

// File: rtl/eco32_core_idu_rfu_mreg.sv
// rtl/eco32_core_idu_rfu_mreg.sv - multi-port byte-lane register file with clear sequencer and bypass
// Optional feature macro: ECO32_CORE_IDU_RFU_ZERO_REG_EN (address 0 reads zero, writes to it dropped).
module eco32_core_idu_rfu_mreg
  import eco32_core_idu_rfu_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int RD_PORTS = 2,
  localparam int NB      = DW / 8,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RD_PORTS*AW-1:0] i_addr,
  input  logic                   w_ena,
  input  logic [NB-1:0]          w_ben,
  input  logic [AW-1:0]          w_addr,
  input  logic [DW-1:0]          w_data,
  output logic [RD_PORTS*DW-1:0] o_data,
  output logic                   o_busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  rfu_state_t              state;
  logic [AW-1:0]           cnt;
  logic                    clearing;
  logic                    wr_ok;
  logic [RD_PORTS*8-1:0]   lane_rd [NB];
  logic [RD_PORTS*DW-1:0]  rd_next;

  assign clearing = (state == RFU_CLEAR);

`ifdef ECO32_CORE_IDU_RFU_ZERO_REG_EN
  assign wr_ok = w_ena && !clearing && (w_addr != '0);
`else
  assign wr_ok = w_ena && !clearing;
`endif

  // During CLEAR the lanes' single write port is owned by the sequencer.
  for (genvar b = 0; b < NB; b++) begin : g_lane
    eco32_core_idu_rfu_lane #(
      .DEPTH    (DEPTH),
      .RD_PORTS (RD_PORTS),
      .AW       (AW)
    ) u_lane (
      .clk   (clk),
      .we    (clearing || (wr_ok && w_ben[b])),
      .waddr (clearing ? cnt : w_addr),
      .wdata (clearing ? 8'h00 : w_data[b*8 +: 8]),
      .raddr (i_addr),
      .rdata (lane_rd[b])
    );
  end

  // Async taps still show pre-write contents, so same-cycle writes are merged per lane.
  always_comb begin
    rd_next = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_ok && w_ben[b] && (w_addr == i_addr[p*AW +: AW]))
          rd_next[p*DW + b*8 +: 8] = w_data[b*8 +: 8];
        else
          rd_next[p*DW + b*8 +: 8] = lane_rd[b][p*8 +: 8];
      end
`ifdef ECO32_CORE_IDU_RFU_ZERO_REG_EN
      if (i_addr[p*AW +: AW] == '0) rd_next[p*DW +: DW] = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RFU_CLEAR;
      cnt    <= '0;
      o_busy <= 1'b1;
      o_data <= '0;
    end else begin
      case (state)
        RFU_CLEAR: begin
          o_data <= '0;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state  <= RFU_READY;
            o_busy <= 1'b0;
          end
        end
        default: begin
          o_data <= rd_next;
        end
      endcase
    end
  end

endmodule
